// File: rtl/rvx_core_fetch_stage_pkg.sv
// Shared types and constants for the RVX fetch stage and its word buffer.
// The NOP constant is also used by decode for bubble insertion.
package rvx_core_fetch_stage_pkg;

    localparam logic [31:0] RVX_NOP_INSTRUCTION = 32'h0000_0013;

    typedef logic [1:0] fetch_count_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    // Stale responses still awaiting discard hold a credit, so they count twice.
    function automatic logic fetch_credit_available(
        input fetch_count_t outstanding,
        input fetch_count_t buffered,
        input fetch_count_t discard
    );
        logic [2:0] total;
        total = {1'b0, outstanding} + {1'b0, buffered} + {1'b0, discard};
        return total < 3'd2;
    endfunction

endpackage

// File: rtl/rvx_core_fetch_buffer.sv
// Two-entry FIFO of {pc, instruction} between the memory response and stage 1.
// Push and pop may coincide; clear empties the buffer in a single cycle.
module rvx_core_fetch_buffer
    import rvx_core_fetch_stage_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_clear,
    output fetch_count_t o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_entries [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    fetch_count_t r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + fetch_count_t'(i_push) - fetch_count_t'(i_pop);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_push && !i_clear) begin
            r_entries[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_entries[r_rd_ptr];

endmodule

// File: rtl/rvx_core_fetch_stage.sv
// RVX instruction fetch: owns the PC, keeps up to two word fetches in flight,
// and feeds decode through the stage-1 instruction/PC registers.
module rvx_core_fetch_stage
    import rvx_core_fetch_stage_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] fetch_address,
    output logic        fetch_request,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_rdata,
    input  logic        fetch_rvalid,
    input  logic        stall_s1,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic [31:0] instruction_s1,
    output logic [31:0] program_counter_s1,
    output logic        instruction_valid_s1
);

    logic [31:0]  r_pc;
    fetch_count_t r_outstanding;
    fetch_count_t r_discard;
    logic [31:0]  r_tag [2];
    logic [31:0]  r_instruction_s1;
    logic [31:0]  r_program_counter_s1;
    logic         r_valid_s1;

    fetch_count_t w_fifo_count;
    fetch_entry_t w_fifo_head;
    fetch_entry_t w_push_entry;
    logic         w_accept;
    logic         w_response;
    logic         w_keep;
    logic         w_bypass;
    logic         w_push;
    logic         w_pop;
    logic         w_tag_wr_idx;

    assign fetch_request = reset_n && !flush
                           && fetch_credit_available(r_outstanding, w_fifo_count, r_discard);
    assign fetch_address = r_pc;
    assign w_accept      = fetch_request && fetch_ready;

    // With nothing outstanding, a response can only be a leftover from before reset.
    assign w_response   = fetch_rvalid && (r_outstanding != '0);
    assign w_keep       = w_response && (r_discard == '0) && !flush;
    assign w_bypass     = w_keep && (w_fifo_count == '0) && !stall_s1;
    assign w_push       = w_keep && !w_bypass;
    assign w_pop        = !flush && !stall_s1 && (w_fifo_count != '0);
    assign w_push_entry = '{pc: r_tag[0], instruction: fetch_rdata};
    assign w_tag_wr_idx = (r_outstanding - fetch_count_t'(w_response)) != '0;

    rvx_core_fetch_buffer u_buffer (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_clear      (flush),
        .o_count      (w_fifo_count),
        .o_head       (w_fifo_head)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc          <= BOOT_ADDRESS;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + fetch_count_t'(w_accept) - fetch_count_t'(w_response);
            if (flush) begin
                r_pc      <= flush_target & ~32'd3;
                r_discard <= r_outstanding - fetch_count_t'(w_response);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_response && (r_discard != '0)) begin
                    r_discard <= r_discard - 2'd1;
                end
            end
        end
    end

    // Tag slot 0 always holds the address of the oldest in-flight request.
    always_ff @(posedge clock) begin
        if (w_response) begin
            r_tag[0] <= r_tag[1];
        end
        if (w_accept) begin
            r_tag[w_tag_wr_idx] <= r_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_instruction_s1     <= RVX_NOP_INSTRUCTION;
            r_program_counter_s1 <= BOOT_ADDRESS;
            r_valid_s1           <= 1'b0;
        end else if (flush) begin
            r_instruction_s1 <= RVX_NOP_INSTRUCTION;
            r_valid_s1       <= 1'b0;
        end else if (!stall_s1) begin
            if (w_fifo_count != '0) begin
                r_instruction_s1     <= w_fifo_head.instruction;
                r_program_counter_s1 <= w_fifo_head.pc;
                r_valid_s1           <= 1'b1;
            end else if (w_bypass) begin
                r_instruction_s1     <= fetch_rdata;
                r_program_counter_s1 <= r_tag[0];
                r_valid_s1           <= 1'b1;
            end else begin
                r_instruction_s1 <= RVX_NOP_INSTRUCTION;
                r_valid_s1       <= 1'b0;
            end
        end
    end

    assign instruction_s1       = r_instruction_s1;
    assign program_counter_s1   = r_program_counter_s1;
    assign instruction_valid_s1 = r_valid_s1;

endmodule
